stage_execute: RTL

//  Y86-64 pipeline execute stage: consumes the E pipeline register (E_* from the decode/E latch) and

---
 rtl/stage_execute.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/stage_execute.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition and the M pipeline register.
// Optional iaddq support (icode C) is enabled by defining IADDQ_EN.
module stage_execute #(
    parameter int          DATA_W   = 64,
    parameter logic [3:0]  RNONE    = 4'hF,
    parameter logic [2:0]  CC_RESET = 3'b100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        E_stat,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        E_ifun,
    input  logic [DATA_W-1:0] E_valC,
    input  logic [DATA_W-1:0] E_valA,
    input  logic [DATA_W-1:0] E_valB,
    input  logic [3:0]        E_dstE,
    input  logic [3:0]        E_dstM,
    input  logic [1:0]        m_stat,
    input  logic [1:0]        W_stat,
    input  logic              M_bubble,
    output logic [DATA_W-1:0] e_valE,
    output logic [3:0]        e_dstE,
    output logic              e_Cnd,
    output logic              ZF,
    output logic              SF,
    output logic              OF,
    output logic [1:0]        M_stat,
    output logic [3:0]        M_icode,
    output logic              M_Cnd,
    output logic [DATA_W-1:0] M_valE,
    output logic [DATA_W-1:0] M_valA,
    output logic [3:0]        M_dstE,
    output logic [3:0]        M_dstM
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] I_IADDQ  = 4'hC;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [1:0] STAT_AOK = 2'd0;

    logic [DATA_W-1:0] w_alu_a;
    logic [DATA_W-1:0] w_alu_b;
    logic [3:0]        w_alufun;
    logic [DATA_W-1:0] w_alu_r;
    logic              w_zf;
    logic              w_sf;
    logic              w_of;
    logic              w_cc_op;
    logic              w_set_cc;
    logic              w_cnd_raw;

    logic              r_zf;
    logic              r_sf;
    logic              r_of;
    logic [1:0]        r_m_stat;
    logic [3:0]        r_m_icode;
    logic              r_m_cnd;
    logic [DATA_W-1:0] r_m_vale;
    logic [DATA_W-1:0] r_m_vala;
    logic [3:0]        r_m_dste;
    logic [3:0]        r_m_dstm;

    always_comb begin
        w_alu_a  = '0;
        w_alu_b  = '0;
        w_alufun = ALU_ADD;
        w_cc_op  = 1'b0;
        case (E_icode)
            I_RRMOVQ:           w_alu_a = E_valA;
            I_IRMOVQ:           w_alu_a = E_valC;
            I_RMMOVQ, I_MRMOVQ: begin
                w_alu_a = E_valC;
                w_alu_b = E_valB;
            end
            I_OPQ: begin
                w_alu_a  = E_valA;
                w_alu_b  = E_valB;
                w_alufun = E_ifun;
                w_cc_op  = 1'b1;
            end
            I_CALL, I_PUSHQ: begin
                w_alu_a = -DATA_W'(8);
                w_alu_b = E_valB;
            end
            I_RET, I_POPQ: begin
                w_alu_a = DATA_W'(8);
                w_alu_b = E_valB;
            end
`ifdef IADDQ_EN
            I_IADDQ: begin
                w_alu_a = E_valC;
                w_alu_b = E_valB;
                w_cc_op = 1'b1;
            end
`else
            I_IADDQ: begin
                w_alu_a = '0;
                w_alu_b = '0;
            end
`endif
            default: begin
                w_alu_a = '0;
                w_alu_b = '0;
            end
        endcase
    end

    // Overflow is only meaningful for add/sub; logical ops leave OF clear.
    always_comb begin
        w_alu_r = '0;
        w_of    = 1'b0;
        case (w_alufun)
            ALU_ADD: begin
                w_alu_r = w_alu_b + w_alu_a;
                w_of    = (w_alu_a[DATA_W-1] == w_alu_b[DATA_W-1]) &&
                          (w_alu_r[DATA_W-1] != w_alu_a[DATA_W-1]);
            end
            ALU_SUB: begin
                w_alu_r = w_alu_b - w_alu_a;
                w_of    = (w_alu_b[DATA_W-1] != w_alu_a[DATA_W-1]) &&
                          (w_alu_r[DATA_W-1] != w_alu_b[DATA_W-1]);
            end
            ALU_AND: w_alu_r = w_alu_b & w_alu_a;
            ALU_XOR: w_alu_r = w_alu_b ^ w_alu_a;
            default: w_alu_r = '0;
        endcase
    end

    assign w_zf = (w_alu_r == '0);
    assign w_sf = w_alu_r[DATA_W-1];

    // Excepting instructions further down the pipe block CC updates from younger ones.
    assign w_set_cc = w_cc_op && (m_stat == STAT_AOK) && (W_stat == STAT_AOK) && !rst;

    // Condition uses the CC register as it stands, before this cycle's update.
    always_comb begin
        case (E_ifun)
            4'h0:    w_cnd_raw = 1'b1;
            4'h1:    w_cnd_raw = (r_sf ^ r_of) | r_zf;
            4'h2:    w_cnd_raw = r_sf ^ r_of;
            4'h3:    w_cnd_raw = r_zf;
            4'h4:    w_cnd_raw = !r_zf;
            4'h5:    w_cnd_raw = !(r_sf ^ r_of);
            4'h6:    w_cnd_raw = !(r_sf ^ r_of) && !r_zf;
            default: w_cnd_raw = 1'b0;
        endcase
    end

    assign e_Cnd  = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) ? w_cnd_raw : 1'b0;
    assign e_valE = w_alu_r;
    assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk) begin
        if (rst) begin
            {r_zf, r_sf, r_of} <= CC_RESET;
            r_m_stat  <= STAT_AOK;
            r_m_icode <= I_NOP;
            r_m_cnd   <= 1'b0;
            r_m_vale  <= '0;
            r_m_vala  <= '0;
            r_m_dste  <= RNONE;
            r_m_dstm  <= RNONE;
        end else begin
            if (w_set_cc) begin
                r_zf <= w_zf;
                r_sf <= w_sf;
                r_of <= w_of;
            end
            if (M_bubble) begin
                r_m_stat  <= STAT_AOK;
                r_m_icode <= I_NOP;
                r_m_cnd   <= 1'b0;
                r_m_vale  <= '0;
                r_m_vala  <= '0;
                r_m_dste  <= RNONE;
                r_m_dstm  <= RNONE;
            end else begin
                r_m_stat  <= E_stat;
                r_m_icode <= E_icode;
                r_m_cnd   <= e_Cnd;
                r_m_vale  <= e_valE;
                r_m_vala  <= E_valA;
                r_m_dste  <= e_dstE;
                r_m_dstm  <= E_dstM;
            end
        end
    end

    assign ZF      = r_zf;
    assign SF      = r_sf;
    assign OF      = r_of;
    assign M_stat  = r_m_stat;
    assign M_icode = r_m_icode;
    assign M_Cnd   = r_m_cnd;
    assign M_valE  = r_m_vale;
    assign M_valA  = r_m_vala;
    assign M_dstE  = r_m_dste;
    assign M_dstM  = r_m_dstm;

endmodule
